// File: rtl/iob_sram_pkg.sv
// iob_sram_pkg: shared FSM encoding, counter width and parameter checks for iob_sram_dp
package iob_sram_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;
  localparam int COLL_CNT_W = 16;
  function automatic bit lanes_ok(int w);
    return w % 8 == 0;
  endfunction
endpackage

// File: rtl/iob_sram_dp_if.sv
// iob_sram_dp_if: one valid/ready memory port with byte-lane write strobes
interface iob_sram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) ();
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_tdp_ram.sv
// iob_tdp_ram: 8-bit true dual-port read-first byte lane; port A wins same-address writes
module iob_tdp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_din,
  output logic [7:0]        a_dout,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_din,
  output logic [7:0]        b_dout
);
  logic [7:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_din;
    if (a_we) mem[a_addr] <= a_din;
    if (a_en) a_dout <= mem[a_addr];
    if (b_en) b_dout <= mem[b_addr];
  end
endmodule

// File: rtl/iob_sram_dp.sv
// iob_sram_dp: dual-port byte-lane SRAM with clear engine, boot-gated i-writes and collision count
module iob_sram_dp import iob_sram_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int OUT_REG  = 0,
  parameter int CLEAR_EN = 1,
  parameter     HEXFILE  = "none"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot,
  iob_sram_dp_if.slave          i_bus,
  iob_sram_dp_if.slave          d_bus,
  output logic                  init_done,
  output logic                  i_wr_blocked,
  output logic [COLL_CNT_W-1:0] coll_cnt
);
  localparam int NB = DATA_W / 8;
  localparam bit CLR = CLEAR_EN != 0 && HEXFILE == "none";
  if (!lanes_ok(DATA_W)) begin : g_bad_width
    $error("DATA_W must be a multiple of 8");
  end
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_addr, a_addr;
  logic [DATA_W-1:0] a_din, i_dout, d_dout, i_q, d_q;
  logic run, clr_we, d_acc, i_acc, d_wr, i_wr, coll, i_blk;
  logic rdy_i1, rdy_d1, rdy_i2, rdy_d2;
  assign run = state == RUN;
  assign clr_we = !run && CLR;
  assign d_acc = run && d_bus.valid;
  assign i_acc = run && i_bus.valid;
  assign d_wr = d_acc && |d_bus.wstrb;
  assign i_wr = i_acc && boot && |i_bus.wstrb;
  assign coll = d_wr && i_wr && d_bus.addr == i_bus.addr;
  assign i_blk = i_bus.valid && |i_bus.wstrb && (!run || !boot);
  assign a_addr = clr_we ? clr_addr : d_bus.addr;
  assign a_din = clr_we ? '0 : d_bus.wdata;
  assign init_done = run;
  always_comb state_n = (run || !CLR || &clr_addr) ? RUN : CLEAR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      clr_addr <= '0;
      {rdy_i1, rdy_d1, rdy_i2, rdy_d2} <= '0;
      i_wr_blocked <= 1'b0;
      coll_cnt <= '0;
      i_q <= '0;
      d_q <= '0;
    end else begin
      state <= state_n;
      clr_addr <= clr_we ? clr_addr + ADDR_W'(1) : clr_addr;
      {rdy_i1, rdy_d1, rdy_i2, rdy_d2} <= {i_acc, d_acc, rdy_i1, rdy_d1};
      i_wr_blocked <= i_blk;
      coll_cnt <= (coll && !(&coll_cnt)) ? coll_cnt + COLL_CNT_W'(1) : coll_cnt;
      i_q <= rdy_i1 ? i_dout : i_q;
      d_q <= rdy_d1 ? d_dout : d_q;
    end
  end
  assign i_bus.ready = OUT_REG != 0 ? rdy_i2 : rdy_i1;
  assign d_bus.ready = OUT_REG != 0 ? rdy_d2 : rdy_d1;
  assign i_bus.rdata = OUT_REG != 0 ? i_q : i_dout;
  assign d_bus.rdata = OUT_REG != 0 ? d_q : d_dout;
  // port A carries the clear engine and the d-port; an i-write losing a collision is dropped on every lane
  for (genvar k = 0; k < NB; k++) begin : g_lane
    iob_tdp_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk    (clk),
      .a_en   (clr_we || d_acc),
      .a_we   (clr_we || (d_acc && d_bus.wstrb[k])),
      .a_addr (a_addr),
      .a_din  (a_din[8*k +: 8]),
      .a_dout (d_dout[8*k +: 8]),
      .b_en   (i_acc),
      .b_we   (i_wr && !coll && i_bus.wstrb[k]),
      .b_addr (i_bus.addr),
      .b_din  (i_bus.wdata[8*k +: 8]),
      .b_dout (i_dout[8*k +: 8])
    );
  end
endmodule

// File: doc/iob_sram_dp.md
# iob_sram_dp

Parametrised dual-port main memory for the SoC, successor to the fixed 32-bit instruction/data SRAM. It serves an instruction port (i_*) and a data port (d_*) with byte-lane writes. It adds configurable width and depth, an optional output register stage, a post-reset clear engine, and boot-gated instruction writes. It also defines write-collision resolution with a saturating collision counter. It sits between the CPU buses and the memory primitives; the boot controller drives `boot`.

## Interface
- DATA_W, 32: word width in bits; multiple of 8; NB = DATA_W/8 byte lanes.
- ADDR_W, 12: word address width; depth = 2^ADDR_W words.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- CLEAR_EN, 1: zero the whole array after reset; forced to 0 when HEXFILE is not "none".
- HEXFILE, "none": per-lane init files named HEXFILE_<lane>.hex.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- boot  in  1  while 1, instruction-port writes are enabled; while 0, i_wstrb is ignored.
- i_valid  in  1  instruction request.
- i_addr  in  ADDR_W  instruction word address.
- i_wdata  in  DATA_W  instruction write data (boot load).
- i_wstrb  in  NB  instruction byte strobes.
- i_rdata  out  DATA_W  instruction read data.
- i_ready  out  1  instruction response.
- d_valid, d_addr, d_wdata, d_wstrb, d_rdata, d_ready: the same set for the data port; writes are always enabled.
- init_done  out  1  array is usable.
- i_wr_blocked  out  1  one-cycle pulse when an i-port write is dropped (boot=0 or during CLEAR).
- coll_cnt  out  16  saturating count of same-address write collisions.

## Operation
- FSM states: CLEAR, RUN.
  - Leaving reset: CLEAR if CLEAR_EN, otherwise RUN.
  - CLEAR: an internal counter walks addresses 0..2^ADDR_W-1 and writes zero on all lanes through the d-side port. It takes exactly 2^ADDR_W cycles, then the FSM moves to RUN.
  - init_done = (state == RUN).
- Requests arriving in CLEAR are dropped: no memory access, no ready. Masters wait for init_done; the SoC holds the CPU in reset until then.
- In RUN, each port accepts one request per cycle whenever valid=1. There is no backpressure.
- Writes:
  - Byte lane k is written when wstrb[k]=1.
  - A request with wstrb != 0 is a write. It still returns ready, and its rdata is don't-care.
- i-port write with boot=0: the write is suppressed and i_wr_blocked pulses. The access still completes with i_ready, as a read of that address.
- Same-address collision in the same cycle:
  - Both ports writing: the d-port wins on every lane. The i-port write is fully suppressed and coll_cnt increments, saturating at 0xFFFF.
  - One port reads while the other writes: the reader gets the old data (read-first).
- Reset mid-operation: the pipeline and ready flags are cleared, and CLEAR restarts from address 0. coll_cnt is cleared.

## Timing
- Reset values: i_ready=0, d_ready=0, init_done=0, i_wr_blocked=0, coll_cnt=0. i_rdata and d_rdata are 0 when OUT_REG=1 and undefined when OUT_REG=0.
- A request accepted at edge N raises ready at edge N+1+OUT_REG. rdata is valid in the same cycle ready=1.
- Back-to-back requests return back-to-back ready pulses. Ready is a 1-cycle pulse per request.
- init_done rises 2^ADDR_W cycles after rst deasserts when CLEAR_EN=1, and 1 cycle after rst deasserts when CLEAR_EN=0.
- i_wr_blocked pulses in the cycle after the dropped request, aligned with the ready pipeline for OUT_REG=0.
- The collision counter updates at the edge following the collision.

## Structure
- Shared package `iob_sram_pkg`:
  - FSM state encoding (CLEAR=0, RUN=1).
  - COLL_CNT_W=16.
  - An elaboration-time check that DATA_W % 8 == 0.
- One sub-module: `iob_tdp_ram` (8-bit true dual-port byte lane), instantiated NB times in a generate loop.
- Port-A mux in front of the lanes selects between the clear engine and the d-port.
- The top level holds the FSM, clear counter, collision logic, ready/output pipeline and error pulse.

## Test plan
- Clear: DATA_W=32, ADDR_W=4, CLEAR_EN=1. After reset, init_done rises at cycle 16. Read of address 7 returns 0x00000000 one cycle later.
- Byte strobes, OUT_REG=1: d-write 0xAABBCCDD with strobe 0b0101 to address 3 over a zeroed word. Read of address 3 returns 0x00BB00DD, with d_ready at N+2.
- Boot gate: boot=0, i-write 0x12345678 to address 2. i_wr_blocked pulses, i_ready=1, and a d-read of address 2 returns 0. Repeating with boot=1, the d-read returns 0x12345678.
- Collision: both ports write address 5 in the same cycle, d=0x11111111 and i=0x22222222 with boot=1. Address 5 reads 0x11111111 and coll_cnt=1. Read-during-write on address 5 returns the old value.
- Streaming: 8 consecutive d-reads with valid held high produce 8 consecutive d_ready pulses with correct data. Asserting rst mid-stream drops ready to 0 immediately, and init_done returns after a full CLEAR.
